// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the blink rate detector:
//   state_e    - classifier FSM states
//   RATE_*     - rate codes, slowest (00) to fastest (11)
//   TOL_SHIFT  - tolerance is T_c >> TOL_SHIFT on each side of the nominal period
// -----------------------------------------------------------------------------
package blink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // Names follow the nominal blink frequency of each code at the default depth
    localparam logic [1:0] RATE_0745 = 2'b00;
    localparam logic [1:0] RATE_149  = 2'b01;
    localparam logic [1:0] RATE_298  = 2'b10;
    localparam logic [1:0] RATE_596  = 2'b11;

    localparam int unsigned TOL_SHIFT = 3;
    localparam int unsigned NUM_RATES = 4;

endpackage : blink_pkg

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer followed by a third flop; emits a one-cycle rising-edge
// pulse on edge_out = sync2 & ~sync3.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   async_in - asynchronous input
//   edge_out - rising-edge pulse, synchronous to clk
// The pulse is held off until all three flops carry real input samples, so an
// input that is already high when reset releases does not look like a rise.
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic       sync1_q;
    logic       sync2_q;
    logic       sync3_q;
    logic [1:0] warm_q;

    // Synchronizer chain plus warm-up counter of cycles since reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end else begin
                warm_q <= warm_q;
            end
        end
    end

    // sync3 only holds a genuine sample once warm_q has reached 3
    assign edge_out = sync2_q & ~sync3_q & (warm_q == 2'd3);

endmodule : sync_edge

// File: rtl/blink_rate_detector.sv
// -----------------------------------------------------------------------------
// blink_rate_detector
// Classifies the rise-to-rise period of an asynchronous blink waveform into one
// of four rates T_c = 2^(N-c) clk cycles (c = 0..3, tolerance T_c/8) and locks
// once two consecutive periods agree.
// Parameters:
//   N        - divider depth (N >= 4)
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   led_in   - asynchronous blink waveform
//   rate     - locked rate code, holds last value when lock is lost
//   valid    - high while locked
//   rate_upd - one-cycle pulse in the cycle valid rises
// -----------------------------------------------------------------------------
module blink_rate_detector
    import blink_pkg::*;
#(
    parameter int N = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       led_in,
    output logic [1:0] rate,
    output logic       valid,
    output logic       rate_upd
);

    localparam int CW = N + 2;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MAX = {CW{1'b1}};
    localparam cnt_t T0      = cnt_t'(1) << N;
    localparam cnt_t TO_LIM  = T0 + (T0 >> TOL_SHIFT);

    // True when period p lies inside the tolerance band of rate code c
    function automatic logic band_hit(input cnt_t p, input logic [1:0] c);
        cnt_t t;
        cnt_t tol;
        t   = cnt_t'(1) << (N - int'(c));
        tol = t >> TOL_SHIFT;
        return (p >= (t - tol)) && (p <= (t + tol));
    endfunction

    logic       edge_s;
    cnt_t       cnt_q;
    cnt_t       cnt_d;
    cnt_t       period_s;
    logic [3:0] match_s;
    logic       hit_s;
    logic [1:0] code_s;
    logic       timeout_s;

    state_e     state_q;
    logic [1:0] cand_q;
    logic [1:0] rate_q;
    logic       valid_q;
    logic       upd_q;

    sync_edge u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (led_in),
        .edge_out (edge_s)
    );

    // Measured period is cnt+1; saturate so a stuck count never wraps to a small period
    assign period_s  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + cnt_t'(1));
    assign timeout_s = (cnt_q > TO_LIM);

    // Per-rate band match for the period ending at this edge
    always_comb begin
        match_s = 4'b0000;
        for (int c = 0; c < int'(NUM_RATES); c++) begin
            match_s[c] = band_hit(period_s, 2'(c));
        end
    end

    // Bands are disjoint, so any pattern other than one-hot is a miss
    always_comb begin
        hit_s  = 1'b0;
        code_s = RATE_0745;
        case (match_s)
            4'b0001: begin hit_s = 1'b1; code_s = RATE_0745; end
            4'b0010: begin hit_s = 1'b1; code_s = RATE_149;  end
            4'b0100: begin hit_s = 1'b1; code_s = RATE_298;  end
            4'b1000: begin hit_s = 1'b1; code_s = RATE_596;  end
            default: begin hit_s = 1'b0; code_s = RATE_0745; end
        endcase
    end

    // Period counter next state: restart on edge, otherwise count and saturate
    always_comb begin
        if (edge_s) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    // Period counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Classifier FSM with registered outputs; an edge wins over a timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cand_q  <= RATE_0745;
            rate_q  <= RATE_0745;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (edge_s) begin
                case (state_q)
                    ST_IDLE: begin
                        // First edge only provides the reference point
                        state_q <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        if (hit_s) begin
                            cand_q  <= code_s;
                            state_q <= ST_CONFIRM;
                        end
                    end
                    ST_CONFIRM: begin
                        if (hit_s && (code_s == cand_q)) begin
                            state_q <= ST_LOCKED;
                            rate_q  <= cand_q;
                            valid_q <= 1'b1;
                            upd_q   <= 1'b1;
                        end else if (hit_s) begin
                            cand_q <= code_s;
                        end else begin
                            state_q <= ST_MEASURE;
                        end
                    end
                    ST_LOCKED: begin
                        if (!(hit_s && (code_s == rate_q))) begin
                            state_q <= ST_MEASURE;
                            valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end else if (timeout_s && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
            end
        end
    end

    assign rate     = rate_q;
    assign valid    = valid_q;
    assign rate_upd = upd_q;

endmodule : blink_rate_detector

// File: tb/tb_blink_rate_detector.sv
// -----------------------------------------------------------------------------
// tb_blink_rate_detector
// Directed scenarios plus randomized period sequences for blink_rate_detector
// at N=6 (periods 64/32/16/8, tolerances 8/4/2/1, timeout when count > 72).
// A period-level reference model predicts rate/valid/rate_upd every cycle.
// -----------------------------------------------------------------------------
module tb_blink_rate_detector;

    localparam int N       = 6;
    localparam int T0      = 1 << N;
    localparam int TO_LIM  = T0 + (T0 / 8);
    localparam int CNT_SAT = (1 << (N + 2)) - 1;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       led_in = 1'b0;
    logic [1:0] rate;
    logic       valid;
    logic       rate_upd;

    int total = 0;
    int bad   = 0;
    int upd_seen = 0;

    // Reference model state
    int m_cnt;
    int m_cyc;
    bit h1, h2, h3;
    bit m_ref;
    int m_cand;
    int m_lock;
    int m_rate;
    bit m_valid;
    bit m_upd;

    blink_rate_detector #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .led_in   (led_in),
        .rate     (rate),
        .valid    (valid),
        .rate_upd (rate_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rate code whose band holds period p, or -1 when none does
    function automatic int classify(input int p);
        for (int c = 0; c < 4; c++) begin
            int t;
            int tol;
            t   = T0 >> c;
            tol = t / 8;
            if (p >= t - tol && p <= t + tol) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_cyc = 0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        m_ref = 1'b0; m_cand = -1; m_lock = -1;
        m_rate = 0; m_valid = 1'b0; m_upd = 1'b0;
    endtask

    // One clock of the model; v is the led level sampled at this edge.
    // A rise sampled at edge k acts at edge k+2 (third edge counting the sample).
    task automatic model_step(input bit v);
        bit ev;
        int p;
        int k;
        m_cyc++;
        ev = (m_cyc >= 4) && h2 && !h3;
        h3 = h2; h2 = h1; h1 = v;
        m_upd = 1'b0;
        if (ev) begin
            p = (m_cnt >= CNT_SAT) ? CNT_SAT : m_cnt + 1;
            k = classify(p);
            m_cnt = 0;
            if (!m_ref) begin
                m_ref = 1'b1;
            end else if (m_lock >= 0) begin
                if (k != m_lock) begin
                    m_lock = -1; m_cand = -1; m_valid = 1'b0;
                end
            end else if (m_cand < 0) begin
                if (k >= 0) m_cand = k;
            end else begin
                if (k == m_cand) begin
                    m_lock = k; m_rate = k; m_valid = 1'b1; m_upd = 1'b1; m_cand = -1;
                end else if (k >= 0) begin
                    m_cand = k;
                end else begin
                    m_cand = -1;
                end
            end
        end else begin
            if (m_ref && m_cnt > TO_LIM) begin
                m_ref = 1'b0; m_cand = -1; m_lock = -1; m_valid = 1'b0;
            end
            m_cnt = (m_cnt >= CNT_SAT) ? CNT_SAT : m_cnt + 1;
        end
    endtask

    task automatic tick(input bit v);
        led_in = v;
        @(posedge clk);
        model_step(v);
        #1;
        check("rate", rate, m_rate);
        check("valid", valid, m_valid);
        check("rate_upd", rate_upd, m_upd);
        if (rate_upd === 1'b1) upd_seen++;
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic wave(input int per, input int n);
        int hi;
        hi = per / 2;
        for (int i = 0; i < n; i++) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock
    task automatic do_reset(input bit lv);
        led_in = lv;
        #2;
        rst = 1'b0;
        #1;
        check("rst_rate", rate, 0);
        check("rst_valid", valid, 0);
        check("rst_upd", rate_upd, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int u0;
        int per;
        int base;
        int tol;
        model_reset();

        // Square wave period 64 from reset: one lock, no further pulses
        do_reset(1'b0);
        hold(1'b0, 5);
        u0 = upd_seen;
        wave(64, 13);
        check("p64_valid", valid, 1);
        check("p64_rate", rate, 0);
        check("p64_upd_count", upd_seen - u0, 1);

        // Lock at 8, then switch to 16
        u0 = upd_seen;
        wave(8, 6);
        check("p8_valid", valid, 1);
        check("p8_rate", rate, 3);
        wave(16, 2);
        check("p16_drop_valid", valid, 0);
        check("p16_drop_rate", rate, 3);
        wave(16, 2);
        check("p16_valid", valid, 1);
        check("p16_rate", rate, 2);
        check("p8_p16_upd_count", upd_seen - u0, 2);

        // 70/58 alternating locks slow rate
        for (int i = 0; i < 4; i++) begin
            wave(70, 1);
            wave(58, 1);
        end
        check("p70_58_valid", valid, 1);
        check("p70_58_rate", rate, 0);

        // Period 73 is outside every band
        u0 = upd_seen;
        wave(73, 6);
        check("p73_valid", valid, 0);
        check("p73_upd_count", upd_seen - u0, 0);

        // Period 24 sits between bands
        u0 = upd_seen;
        wave(24, 8);
        check("p24_valid", valid, 0);
        check("p24_upd_count", upd_seen - u0, 0);

        // Lock at 32, stall the input, then resume
        wave(32, 5);
        check("p32_valid", valid, 1);
        check("p32_rate", rate, 1);
        hold(1'b0, 90);
        check("timeout_valid", valid, 0);
        check("timeout_rate", rate, 1);
        wave(32, 4);
        check("relock_valid", valid, 1);
        check("relock_rate", rate, 1);

        // Reset while locked, then reset during CONFIRM
        do_reset(1'b0);
        hold(1'b0, 3);
        wave(16, 2);
        check("confirm_valid", valid, 0);
        do_reset(1'b0);
        hold(1'b0, 3);
        wave(16, 2);
        check("post_rst_2edges_valid", valid, 0);
        wave(16, 1);
        check("post_rst_3edges_valid", valid, 1);
        check("post_rst_rate", rate, 2);

        // High input at reset release is not a rise
        do_reset(1'b1);
        hold(1'b1, 10);
        hold(1'b0, 6);
        wave(32, 2);
        check("high_rel_2edges_valid", valid, 0);
        wave(32, 1);
        check("high_rel_3edges_valid", valid, 1);
        check("high_rel_rate", rate, 1);

        // Randomized segments of in-band, jittered and arbitrary periods
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                hold(1'b0, int'($urandom_range(60, 100)));
            end else if ($urandom_range(0, 3) == 0) begin
                wave(int'($urandom_range(5, 90)), int'($urandom_range(1, 4)));
            end else begin
                base = T0 >> $urandom_range(0, 3);
                tol  = base / 8;
                per  = base + int'($urandom_range(0, 2 * tol)) - tol;
                wave(per, int'($urandom_range(1, 6)));
            end
        end
        hold(1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_blink_rate_detector
